// File: rtl/mem_stage_pkg.sv
// Shared widths and access-width encoding for the MEM pipeline stage.
// Imported by data_memory and mem_stage.
package mem_stage_pkg;

    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int NB_PC    = 32;
    localparam int NB_DEPTH = 6;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_BYTE = 2'd1;
    localparam logic [1:0] ACC_HALF = 2'd2;
    localparam logic [1:0] ACC_WORD = 2'd3;

    // Resolves overlapping width enables: word beats halfword beats byte.
    function automatic logic [1:0] sel_width(input logic word_en, input logic half_en,
                                             input logic byte_en);
        if (word_en)      return ACC_WORD;
        else if (half_en) return ACC_HALF;
        else if (byte_en) return ACC_BYTE;
        else              return ACC_NONE;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables, one asynchronous
// read port for the pipeline and a second asynchronous read port for debug.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA  = mem_stage_pkg::NB_DATA,
    parameter int NB_DEPTH = mem_stage_pkg::NB_DEPTH
) (
    input  logic                  clock,
    input  logic [3:0]            byte_we,
    input  logic [NB_DEPTH-1:0]   addr,
    input  logic [NB_DATA-1:0]    wdata,
    output logic [NB_DATA-1:0]    rdata,
    input  logic [NB_DEPTH-1:0]   du_addr,
    output logic [NB_DATA-1:0]    du_rdata
);

    // Contents are deliberately never reset so a reset keeps program data.
    logic [NB_DATA-1:0] mem [0:(1<<NB_DEPTH)-1];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
    end

    assign rdata    = mem[addr];
    assign du_rdata = mem[du_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, load/store alignment and extension,
// MEM/WB register, sticky halt and a stall-time debug read port.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA  = mem_stage_pkg::NB_DATA,
    parameter int NB_REG   = mem_stage_pkg::NB_REG,
    parameter int NB_PC    = mem_stage_pkg::NB_PC,
    parameter int NB_DEPTH = mem_stage_pkg::NB_DEPTH
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_MEM_enable,
    input  logic [NB_DATA-1:0]  i_MEM_alu_result,
    input  logic [NB_DATA-1:0]  i_MEM_data_b,
    input  logic                i_MEM_mem_read,
    input  logic                i_MEM_mem_write,
    input  logic                i_MEM_byte_en,
    input  logic                i_MEM_halfword_en,
    input  logic                i_MEM_word_en,
    input  logic                i_MEM_signed,
    input  logic                i_MEM_branch,
    input  logic                i_MEM_zero,
    input  logic                i_MEM_reg_write,
    input  logic                i_MEM_mem_to_reg,
    input  logic                i_MEM_r31_ctrl,
    input  logic                i_MEM_hlt,
    input  logic                i_MEM_jump,
    input  logic [NB_PC-1:0]    i_MEM_branch_addr,
    input  logic [NB_PC-1:0]    i_MEM_pc,
    input  logic [NB_REG-1:0]   i_MEM_selected_reg,
    input  logic                i_MEM_du_rd_en,
    input  logic [NB_DEPTH-1:0] i_MEM_du_addr,
    output logic                o_MEM_pc_src,
    output logic [NB_PC-1:0]    o_MEM_branch_addr,
    output logic [NB_DATA-1:0]  o_MEM_read_data,
    output logic [NB_DATA-1:0]  o_MEM_alu_result,
    output logic [NB_REG-1:0]   o_MEM_selected_reg,
    output logic                o_MEM_reg_write,
    output logic                o_MEM_mem_to_reg,
    output logic                o_MEM_r31_ctrl,
    output logic                o_MEM_hlt,
    output logic [NB_PC-1:0]    o_MEM_pc,
    output logic                o_MEM_misaligned,
    output logic [NB_DATA-1:0]  o_MEM_du_data,
    output logic                o_MEM_du_valid
);

    logic [1:0]          width;
    logic [1:0]          lane;
    logic [NB_DEPTH-1:0] word_idx;
    logic                misaligned;
    logic                store_ok;
    logic                du_req;
    logic [3:0]          byte_we;
    logic [NB_DATA-1:0]  wdata;
    logic [NB_DATA-1:0]  rd_word;
    logic [NB_DATA-1:0]  du_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [NB_DATA-1:0]  load_data;
    logic                unused_jump;

    // Jump is resolved upstream; it only passes through this stage's interface.
    assign unused_jump = i_MEM_jump;

    assign o_MEM_pc_src      = i_MEM_branch & i_MEM_zero;
    assign o_MEM_branch_addr = i_MEM_branch_addr;

    assign width    = sel_width(i_MEM_word_en, i_MEM_halfword_en, i_MEM_byte_en);
    assign lane     = i_MEM_alu_result[1:0];
    assign word_idx = i_MEM_alu_result[NB_DEPTH+1:2];

    assign misaligned = (i_MEM_mem_read | i_MEM_mem_write) &
                        (((width == ACC_HALF) & lane[0]) |
                         ((width == ACC_WORD) & (lane != 2'b00)));

    // Writes need reset released, an advancing pipe, no halt and an aligned access.
    assign store_ok = i_reset & i_MEM_enable & i_MEM_mem_write & ~misaligned & ~o_MEM_hlt;
    assign du_req   = ~i_MEM_enable & i_MEM_du_rd_en;

    always_comb begin
        byte_we = 4'b0000;
        wdata   = i_MEM_data_b;
        if (store_ok) begin
            case (width)
                ACC_BYTE: begin
                    byte_we = 4'b0001 << lane;
                    wdata   = {4{i_MEM_data_b[7:0]}};
                end
                ACC_HALF: begin
                    byte_we = lane[1] ? 4'b1100 : 4'b0011;
                    wdata   = {2{i_MEM_data_b[15:0]}};
                end
                ACC_WORD: byte_we = 4'b1111;
                default:  byte_we = 4'b0000;
            endcase
        end
    end

    data_memory #(
        .NB_DATA  (NB_DATA),
        .NB_DEPTH (NB_DEPTH)
    ) u_data_memory (
        .clock    (i_clock),
        .byte_we  (byte_we),
        .addr     (word_idx),
        .wdata    (wdata),
        .rdata    (rd_word),
        .du_addr  (i_MEM_du_addr),
        .du_rdata (du_word)
    );

    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        if (i_MEM_mem_read && !misaligned) begin
            case (width)
                ACC_BYTE: load_data = {{(NB_DATA-8){i_MEM_signed & rd_byte[7]}}, rd_byte};
                ACC_HALF: load_data = {{(NB_DATA-16){i_MEM_signed & rd_half[15]}}, rd_half};
                ACC_WORD: load_data = rd_word;
                default:  load_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_MEM_read_data    <= '0;
            o_MEM_alu_result   <= '0;
            o_MEM_selected_reg <= '0;
            o_MEM_reg_write    <= 1'b0;
            o_MEM_mem_to_reg   <= 1'b0;
            o_MEM_r31_ctrl     <= 1'b0;
            o_MEM_hlt          <= 1'b0;
            o_MEM_pc           <= '0;
            o_MEM_misaligned   <= 1'b0;
            o_MEM_du_data      <= '0;
            o_MEM_du_valid     <= 1'b0;
        end else begin
            if (i_MEM_enable) begin
                o_MEM_read_data    <= load_data;
                o_MEM_alu_result   <= i_MEM_alu_result;
                o_MEM_selected_reg <= i_MEM_selected_reg;
                o_MEM_reg_write    <= i_MEM_reg_write;
                o_MEM_mem_to_reg   <= i_MEM_mem_to_reg;
                o_MEM_r31_ctrl     <= i_MEM_r31_ctrl;
                o_MEM_hlt          <= o_MEM_hlt | i_MEM_hlt;
                o_MEM_pc           <= i_MEM_pc;
                o_MEM_misaligned   <= misaligned;
            end
            // du_valid is a one-cycle qualifier for du_data; no ready, the consumer must sample it.
            o_MEM_du_valid <= du_req;
            if (du_req) o_MEM_du_data <= du_word;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors checked with immediate
// assertions, ending in a single pass-count summary.
module tb_mem_stage;

    logic        i_clock;
    logic        i_reset;
    logic        i_MEM_enable;
    logic [31:0] i_MEM_alu_result;
    logic [31:0] i_MEM_data_b;
    logic        i_MEM_mem_read;
    logic        i_MEM_mem_write;
    logic        i_MEM_byte_en;
    logic        i_MEM_halfword_en;
    logic        i_MEM_word_en;
    logic        i_MEM_signed;
    logic        i_MEM_branch;
    logic        i_MEM_zero;
    logic        i_MEM_reg_write;
    logic        i_MEM_mem_to_reg;
    logic        i_MEM_r31_ctrl;
    logic        i_MEM_hlt;
    logic        i_MEM_jump;
    logic [31:0] i_MEM_branch_addr;
    logic [31:0] i_MEM_pc;
    logic [4:0]  i_MEM_selected_reg;
    logic        i_MEM_du_rd_en;
    logic [5:0]  i_MEM_du_addr;
    logic        o_MEM_pc_src;
    logic [31:0] o_MEM_branch_addr;
    logic [31:0] o_MEM_read_data;
    logic [31:0] o_MEM_alu_result;
    logic [4:0]  o_MEM_selected_reg;
    logic        o_MEM_reg_write;
    logic        o_MEM_mem_to_reg;
    logic        o_MEM_r31_ctrl;
    logic        o_MEM_hlt;
    logic [31:0] o_MEM_pc;
    logic        o_MEM_misaligned;
    logic [31:0] o_MEM_du_data;
    logic        o_MEM_du_valid;

    int checks_total  = 0;
    int checks_passed = 0;

    mem_stage dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_MEM_enable       (i_MEM_enable),
        .i_MEM_alu_result   (i_MEM_alu_result),
        .i_MEM_data_b       (i_MEM_data_b),
        .i_MEM_mem_read     (i_MEM_mem_read),
        .i_MEM_mem_write    (i_MEM_mem_write),
        .i_MEM_byte_en      (i_MEM_byte_en),
        .i_MEM_halfword_en  (i_MEM_halfword_en),
        .i_MEM_word_en      (i_MEM_word_en),
        .i_MEM_signed       (i_MEM_signed),
        .i_MEM_branch       (i_MEM_branch),
        .i_MEM_zero         (i_MEM_zero),
        .i_MEM_reg_write    (i_MEM_reg_write),
        .i_MEM_mem_to_reg   (i_MEM_mem_to_reg),
        .i_MEM_r31_ctrl     (i_MEM_r31_ctrl),
        .i_MEM_hlt          (i_MEM_hlt),
        .i_MEM_jump         (i_MEM_jump),
        .i_MEM_branch_addr  (i_MEM_branch_addr),
        .i_MEM_pc           (i_MEM_pc),
        .i_MEM_selected_reg (i_MEM_selected_reg),
        .i_MEM_du_rd_en     (i_MEM_du_rd_en),
        .i_MEM_du_addr      (i_MEM_du_addr),
        .o_MEM_pc_src       (o_MEM_pc_src),
        .o_MEM_branch_addr  (o_MEM_branch_addr),
        .o_MEM_read_data    (o_MEM_read_data),
        .o_MEM_alu_result   (o_MEM_alu_result),
        .o_MEM_selected_reg (o_MEM_selected_reg),
        .o_MEM_reg_write    (o_MEM_reg_write),
        .o_MEM_mem_to_reg   (o_MEM_mem_to_reg),
        .o_MEM_r31_ctrl     (o_MEM_r31_ctrl),
        .o_MEM_hlt          (o_MEM_hlt),
        .o_MEM_pc           (o_MEM_pc),
        .o_MEM_misaligned   (o_MEM_misaligned),
        .o_MEM_du_data      (o_MEM_du_data),
        .o_MEM_du_valid     (o_MEM_du_valid)
    );

    // Clock / reset
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // One clock edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        i_MEM_enable       = 1'b1;
        i_MEM_alu_result   = '0;
        i_MEM_data_b       = '0;
        i_MEM_mem_read     = 1'b0;
        i_MEM_mem_write    = 1'b0;
        i_MEM_byte_en      = 1'b0;
        i_MEM_halfword_en  = 1'b0;
        i_MEM_word_en      = 1'b0;
        i_MEM_signed       = 1'b0;
        i_MEM_branch       = 1'b0;
        i_MEM_zero         = 1'b0;
        i_MEM_reg_write    = 1'b0;
        i_MEM_mem_to_reg   = 1'b0;
        i_MEM_r31_ctrl     = 1'b0;
        i_MEM_hlt          = 1'b0;
        i_MEM_jump         = 1'b0;
        i_MEM_branch_addr  = '0;
        i_MEM_pc           = '0;
        i_MEM_selected_reg = '0;
        i_MEM_du_rd_en     = 1'b0;
        i_MEM_du_addr      = '0;
    endtask

    // Driver: one pipeline access (width: 0 none, 1 byte, 2 half, 3 word)
    task automatic access(input logic wr, input logic rd, input logic [1:0] w,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] data);
        idle_inputs();
        i_MEM_mem_write   = wr;
        i_MEM_mem_read    = rd;
        i_MEM_byte_en     = (w == 2'd1);
        i_MEM_halfword_en = (w == 2'd2);
        i_MEM_word_en     = (w == 2'd3);
        i_MEM_signed      = sgn;
        i_MEM_alu_result  = addr;
        i_MEM_data_b      = data;
    endtask

    task automatic debug_read(input logic en, input logic [5:0] addr);
        idle_inputs();
        i_MEM_enable   = en;
        i_MEM_du_rd_en = 1'b1;
        i_MEM_du_addr  = addr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"}, o_MEM_read_data, 32'h0);
        check({tag, "_alu_result"}, o_MEM_alu_result, 32'h0);
        check({tag, "_sel_reg"}, {27'h0, o_MEM_selected_reg}, 32'h0);
        check({tag, "_ctrl"}, {28'h0, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl,
                               o_MEM_misaligned}, 32'h0);
        check({tag, "_hlt"}, {31'h0, o_MEM_hlt}, 32'h0);
        check({tag, "_pc"}, o_MEM_pc, 32'h0);
        check({tag, "_du_data"}, o_MEM_du_data, 32'h0);
        check({tag, "_du_valid"}, {31'h0, o_MEM_du_valid}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b0;
        step();
        step();
        check_all_zero("reset");
        i_reset = 1'b1;

        // Word store then word load, with MEM/WB pass-through fields
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'hDEADBEEF);
        step();
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        i_MEM_pc = 32'h0000_0100; i_MEM_selected_reg = 5'd5;
        i_MEM_reg_write = 1'b1; i_MEM_mem_to_reg = 1'b1; i_MEM_r31_ctrl = 1'b1;
        step();
        check("lw_0x10", o_MEM_read_data, 32'hDEADBEEF);
        check("lw_pc", o_MEM_pc, 32'h0000_0100);
        check("lw_alu", o_MEM_alu_result, 32'h10);
        check("lw_sel_reg", {27'h0, o_MEM_selected_reg}, 32'd5);
        check("lw_ctrl", {28'h0, o_MEM_reg_write, o_MEM_mem_to_reg, o_MEM_r31_ctrl,
                          o_MEM_misaligned}, 32'b1110);

        // Byte store into lane 3, then signed/unsigned byte and word loads
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h12345680);
        step();
        access(1'b0, 1'b1, 2'd1, 1'b1, 32'h13, 32'h0);
        step();
        check("lb_signed", o_MEM_read_data, 32'hFFFFFF80);
        access(1'b0, 1'b1, 2'd1, 1'b0, 32'h13, 32'h0);
        step();
        check("lbu", o_MEM_read_data, 32'h00000080);
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        step();
        check("lw_after_sb", o_MEM_read_data, 32'h80ADBEEF);
        access(1'b0, 1'b1, 2'd2, 1'b1, 32'h12, 32'h0);
        step();
        check("lh_signed", o_MEM_read_data, 32'hFFFF80AD);
        access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
        step();
        check("lhu", o_MEM_read_data, 32'h0000BEEF);
        // Upper address bits ignored: 0x110 aliases 0x10
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h110, 32'h0);
        step();
        check("lw_wrap", o_MEM_read_data, 32'h80ADBEEF);

        // Misaligned halfword store alongside a taken branch
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h00001234);
        i_MEM_branch = 1'b1; i_MEM_zero = 1'b1; i_MEM_branch_addr = 32'h0000_0400;
        #1;
        check("pc_src_taken", {31'h0, o_MEM_pc_src}, 32'h1);
        check("branch_addr", o_MEM_branch_addr, 32'h0000_0400);
        i_MEM_zero = 1'b0;
        #1;
        check("pc_src_not_taken", {31'h0, o_MEM_pc_src}, 32'h0);
        step();
        check("sh_misaligned_flag", {31'h0, o_MEM_misaligned}, 32'h1);
        check("sh_misaligned_rd", o_MEM_read_data, 32'h0);
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        step();
        check("lw_after_bad_sh", o_MEM_read_data, 32'h80ADBEEF);
        check("misaligned_clear", {31'h0, o_MEM_misaligned}, 32'h0);
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h12, 32'h0);
        step();
        check("lw_misaligned_rd", o_MEM_read_data, 32'h0);
        check("lw_misaligned_flag", {31'h0, o_MEM_misaligned}, 32'h1);

        // Aligned halfword store into upper half; width priority and no-width read
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h14, 32'h0);
        step();
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h16, 32'h5555CAFE);
        step();
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h14, 32'h0);
        i_MEM_byte_en = 1'b1; i_MEM_halfword_en = 1'b1;
        step();
        check("sh_upper_prio_word", o_MEM_read_data, 32'hCAFE0000);
        access(1'b0, 1'b1, 2'd0, 1'b0, 32'h14, 32'h0);
        step();
        check("no_width_read", o_MEM_read_data, 32'h0);

        // Stall: outputs hold, store suppressed, debug read pulses while held
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        i_MEM_pc = 32'h0000_0200;
        step();
        debug_read(1'b0, 6'd4);
        i_MEM_mem_write = 1'b1; i_MEM_word_en = 1'b1; i_MEM_alu_result = 32'h10;
        i_MEM_data_b = 32'h0; i_MEM_pc = 32'h0000_0999;
        step();
        check("du_valid_1", {31'h0, o_MEM_du_valid}, 32'h1);
        check("du_data_w4", o_MEM_du_data, 32'h80ADBEEF);
        check("stall_pc_hold", o_MEM_pc, 32'h0000_0200);
        check("stall_rd_hold", o_MEM_read_data, 32'h80ADBEEF);
        i_MEM_mem_write = 1'b0; i_MEM_du_addr = 6'd5;
        step();
        check("du_valid_2", {31'h0, o_MEM_du_valid}, 32'h1);
        check("du_data_w5", o_MEM_du_data, 32'hCAFE0000);
        debug_read(1'b1, 6'd4);
        step();
        check("du_ignored_enabled", {31'h0, o_MEM_du_valid}, 32'h0);
        access(1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        step();
        check("lw_after_stalled_sw", o_MEM_read_data, 32'h80ADBEEF);

        // Halt is sticky and blocks later stores; debug reads still work
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h20, 32'h11111111);
        step();
        idle_inputs();
        i_MEM_hlt = 1'b1;
        step();
        check("hlt_set", {31'h0, o_MEM_hlt}, 32'h1);
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h20, 32'h22222222);
        step();
        check("hlt_sticky", {31'h0, o_MEM_hlt}, 32'h1);
        debug_read(1'b0, 6'd8);
        step();
        check("hlt_du_valid", {31'h0, o_MEM_du_valid}, 32'h1);
        check("hlt_store_blocked", o_MEM_du_data, 32'h11111111);

        // Reset during a store: all outputs clear, store dropped, memory retained
        access(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h33333333);
        i_MEM_du_rd_en = 1'b1; i_MEM_du_addr = 6'd4;
        i_reset = 1'b0;
        step();
        check_all_zero("rst_store");
        i_reset = 1'b1;
        debug_read(1'b0, 6'd4);
        step();
        check("rst_mem_kept", o_MEM_du_data, 32'h80ADBEEF);
        check("rst_hlt_clear", {31'h0, o_MEM_hlt}, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
